qam16_carrier_mod: RTL and testbench



---
 rtl/qam_pkg.sv | 31 +++
 rtl/qam_sin_lut.sv | 53 +++++
 rtl/qam16_carrier_mod.sv | 107 ++++++++++
 tb/tb_qam16_carrier_mod.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qam_pkg.sv
// Shared types, constants and helpers for the 16-QAM IF upconverter.
package qam_pkg;

   // Width of one carrier sample taken from the quarter-wave table.
   localparam int SAMPLE_W = 8;

   // A 16-QAM amplitude level in {-3, -1, +1, +3}. Zero is used only while idle.
   typedef logic signed [2:0]          level_t;

   // A signed carrier sample with a peak of +/-127.
   typedef logic signed [SAMPLE_W-1:0] sample_t;

   localparam level_t LVL_M3 = 3'sb101;
   localparam level_t LVL_M1 = 3'sb111;
   localparam level_t LVL_P1 = 3'sb001;
   localparam level_t LVL_P3 = 3'sb011;

   // Gray-coded symbol half to amplitude level. Adjacent levels differ in one bit.
   function automatic level_t gray2lvl(input logic [1:0] i_bits);
      level_t r_lvl;
      case (i_bits)
         2'b00:   r_lvl = LVL_M3;
         2'b01:   r_lvl = LVL_M1;
         2'b11:   r_lvl = LVL_P1;
         2'b10:   r_lvl = LVL_P3;
         default: r_lvl = 3'sb000;
      endcase
      return r_lvl;
   endfunction

endpackage

// File: rtl/qam_sin_lut.sv
// Combinational sine of an 8-bit phase address: a 64-entry quarter-wave
// table, mirrored for odd quadrants and negated for the lower half-plane.
// The table is sampled at half-step offsets, so no entry is ever zero and
// the quadrant seams need no special cases.
module qam_sin_lut
   import qam_pkg::*;
(
   input  logic [7:0] i_addr,
   output sample_t    o_sample
);

   logic [5:0] w_idx;
   logic [6:0] w_mag;

   // round(127 * sin(pi/2 * (k + 0.5) / 64)) for k = 0..63.
   function automatic logic [6:0] quarter_sine(input logic [5:0] i_k);
      logic [6:0] r_t;
      case (i_k)
         6'd0:  r_t = 7'd2;   6'd1:  r_t = 7'd5;   6'd2:  r_t = 7'd8;   6'd3:  r_t = 7'd11;
         6'd4:  r_t = 7'd14;  6'd5:  r_t = 7'd17;  6'd6:  r_t = 7'd20;  6'd7:  r_t = 7'd23;
         6'd8:  r_t = 7'd26;  6'd9:  r_t = 7'd29;  6'd10: r_t = 7'd32;  6'd11: r_t = 7'd35;
         6'd12: r_t = 7'd38;  6'd13: r_t = 7'd41;  6'd14: r_t = 7'd44;  6'd15: r_t = 7'd47;
         6'd16: r_t = 7'd50;  6'd17: r_t = 7'd53;  6'd18: r_t = 7'd56;  6'd19: r_t = 7'd58;
         6'd20: r_t = 7'd61;  6'd21: r_t = 7'd64;  6'd22: r_t = 7'd67;  6'd23: r_t = 7'd69;
         6'd24: r_t = 7'd72;  6'd25: r_t = 7'd74;  6'd26: r_t = 7'd77;  6'd27: r_t = 7'd79;
         6'd28: r_t = 7'd82;  6'd29: r_t = 7'd84;  6'd30: r_t = 7'd86;  6'd31: r_t = 7'd89;
         6'd32: r_t = 7'd91;  6'd33: r_t = 7'd93;  6'd34: r_t = 7'd95;  6'd35: r_t = 7'd97;
         6'd36: r_t = 7'd99;  6'd37: r_t = 7'd101; 6'd38: r_t = 7'd103; 6'd39: r_t = 7'd105;
         6'd40: r_t = 7'd106; 6'd41: r_t = 7'd108; 6'd42: r_t = 7'd110; 6'd43: r_t = 7'd111;
         6'd44: r_t = 7'd113; 6'd45: r_t = 7'd114; 6'd46: r_t = 7'd115; 6'd47: r_t = 7'd117;
         6'd48: r_t = 7'd118; 6'd49: r_t = 7'd119; 6'd50: r_t = 7'd120; 6'd51: r_t = 7'd121;
         6'd52: r_t = 7'd122; 6'd53: r_t = 7'd123; 6'd54: r_t = 7'd124; 6'd55: r_t = 7'd124;
         6'd56: r_t = 7'd125; 6'd57: r_t = 7'd125; 6'd58: r_t = 7'd126; 6'd59: r_t = 7'd126;
         6'd60: r_t = 7'd127; 6'd61: r_t = 7'd127; 6'd62: r_t = 7'd127; 6'd63: r_t = 7'd127;
         default: r_t = 7'd0;
      endcase
      return r_t;
   endfunction

   // Odd quadrants walk the table backwards: 63 - k is the bitwise inverse of k.
   assign w_idx = i_addr[6] ? ~i_addr[5:0] : i_addr[5:0];
   assign w_mag = quarter_sine(w_idx);

   // Quadrants 2 and 3 are the negative half of the sine.
   always_comb begin
      if (i_addr[7]) begin
         o_sample = -$signed({1'b0, w_mag});
      end else begin
         o_sample = $signed({1'b0, w_mag});
      end
   end

endmodule

// File: rtl/qam16_carrier_mod.sv
// 16-QAM digital IF upconverter: Gray-maps the I/Q symbol halves to
// amplitude levels and mixes them onto a quadrature carrier,
// producing mod_out = I*cos - Q*sin, one sample per clock.
// Pipeline: phase/level registers -> S1 (carrier + levels) -> S2 (mix).
// PHASE_W must be at least 8; the top 8 phase bits address the carrier.
module qam16_carrier_mod
   import qam_pkg::*;
#(
   parameter int PHASE_W = 10,
   parameter int AMP_W   = 8,
   parameter int OUT_W   = 11
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sym_valid,
   input  logic [1:0]               SigI,
   input  logic [1:0]               SigQ,
   input  logic [PHASE_W-1:0]       fcw,
   output logic signed [OUT_W-1:0]  mod_out,
   output logic                     out_valid
);

   logic [PHASE_W-1:0]      r_phase;
   level_t                  r_lvl_i;
   level_t                  r_lvl_q;
   logic                    r_active;

   logic signed [AMP_W-1:0] r_s1_sin;
   logic signed [AMP_W-1:0] r_s1_cos;
   level_t                  r_s1_lvl_i;
   level_t                  r_s1_lvl_q;
   logic                    r_s1_active;

   logic [7:0]              w_addr_sin;
   logic [7:0]              w_addr_cos;
   sample_t                 w_sin;
   sample_t                 w_cos;
   logic signed [OUT_W-1:0] w_mix;

   // Cosine is the sine a quarter turn ahead; the 8-bit add wraps naturally.
   assign w_addr_sin = r_phase[PHASE_W-1 -: 8];
   assign w_addr_cos = w_addr_sin + 8'd64;

   qam_sin_lut u_sin_lut (
      .i_addr   (w_addr_sin),
      .o_sample (w_sin)
   );

   qam_sin_lut u_cos_lut (
      .i_addr   (w_addr_cos),
      .o_sample (w_cos)
   );

   // Mix at full output width; the largest magnitude is 3*127*2 = 762.
   assign w_mix = (OUT_W'(r_s1_lvl_i) * OUT_W'(r_s1_cos))
                - (OUT_W'(r_s1_lvl_q) * OUT_W'(r_s1_sin));

   // Phase accumulator and symbol register; active latches on the first symbol.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase  <= '0;
         r_lvl_i  <= 3'sb000;
         r_lvl_q  <= 3'sb000;
         r_active <= 1'b0;
      end else begin
         r_phase <= r_phase + fcw;
         if (sym_valid) begin
            r_lvl_i  <= gray2lvl(SigI);
            r_lvl_q  <= gray2lvl(SigQ);
            r_active <= 1'b1;
         end else begin
            r_lvl_i  <= r_lvl_i;
            r_lvl_q  <= r_lvl_q;
            r_active <= r_active;
         end
      end
   end

   // S1: capture the carrier samples alongside the levels they will scale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_sin    <= '0;
         r_s1_cos    <= '0;
         r_s1_lvl_i  <= 3'sb000;
         r_s1_lvl_q  <= 3'sb000;
         r_s1_active <= 1'b0;
      end else begin
         r_s1_sin    <= w_sin;
         r_s1_cos    <= w_cos;
         r_s1_lvl_i  <= r_lvl_i;
         r_s1_lvl_q  <= r_lvl_q;
         r_s1_active <= r_active;
      end
   end

   // S2: registered passband sample and its qualifier.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mod_out   <= '0;
         out_valid <= 1'b0;
      end else begin
         mod_out   <= w_mix;
         out_valid <= r_s1_active;
      end
   end

endmodule

// File: tb/tb_qam16_carrier_mod.sv
// Self-checking bench for qam16_carrier_mod: a behavioural model computes
// each expected sample from the carrier formula and pushes it into a
// scoreboard queue; it is popped two clocks later against the DUT output.
module tb_qam16_carrier_mod;

   localparam int PHASE_W = 10;
   localparam int AMP_W   = 8;
   localparam int OUT_W   = 11;

   logic                    clk;
   logic                    rst;
   logic                    sym_valid;
   logic [1:0]              SigI;
   logic [1:0]              SigQ;
   logic [PHASE_W-1:0]      fcw;
   logic signed [OUT_W-1:0] mod_out;
   logic                    out_valid;

   typedef struct {
      int v;
      int val;
   } exp_t;

   exp_t               sb_q[$];
   logic [PHASE_W-1:0] m_phase;
   int                 m_lvl_i;
   int                 m_lvl_q;
   int                 m_active;
   int                 n_checks;
   int                 n_pass;

   qam16_carrier_mod #(
      .PHASE_W (PHASE_W),
      .AMP_W   (AMP_W),
      .OUT_W   (OUT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sym_valid (sym_valid),
      .SigI      (SigI),
      .SigQ      (SigQ),
      .fcw       (fcw),
      .mod_out   (mod_out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int gray(input logic [1:0] g);
      case (g)
         2'b00:   return -3;
         2'b01:   return -1;
         2'b11:   return 1;
         default: return 3;
      endcase
   endfunction

   function automatic int tval(input int k);
      real x;
      x = 127.0 * $sin(3.14159265358979 * (k + 0.5) / 128.0);
      return $rtoi(x + 0.5);
   endfunction

   function automatic int carrier(input logic [7:0] a);
      int k;
      k = int'(a[5:0]);
      case (a[7:6])
         2'd0:    return tval(k);
         2'd1:    return tval(63 - k);
         2'd2:    return -tval(k);
         default: return -tval(63 - k);
      endcase
   endfunction

   // One clock: advance the model with the inputs present at the edge,
   // push its expectation, then compare the DUT against the entry from two edges ago.
   task automatic tick();
      exp_t       e;
      exp_t       o;
      logic [7:0] a_sin;
      logic [7:0] a_cos;
      @(posedge clk);
      m_phase = m_phase + fcw;
      if (sym_valid) begin
         m_lvl_i  = gray(SigI);
         m_lvl_q  = gray(SigQ);
         m_active = 1;
      end
      a_sin = m_phase[PHASE_W-1 -: 8];
      a_cos = a_sin + 8'd64;
      e.v   = m_active;
      e.val = m_lvl_i * carrier(a_cos) - m_lvl_q * carrier(a_sin);
      sb_q.push_back(e);
      #1;
      o = sb_q.pop_front();
      chk("out_valid", int'(out_valid), o.v);
      chk("mod_out", int'(mod_out), o.val);
   endtask

   task automatic do_reset();
      exp_t z;
      #2;
      rst       = 1'b1;
      sym_valid = 1'b0;
      #1;
      chk("rst_mod_out", int'(mod_out), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_phase", int'(dut.r_phase), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      m_phase  = '0;
      m_lvl_i  = 0;
      m_lvl_q  = 0;
      m_active = 0;
      sb_q.delete();
      z.v   = 0;
      z.val = 0;
      sb_q.push_back(z);
      sb_q.push_back(z);
   endtask

   task automatic strobe(input logic [1:0] si, input logic [1:0] sq);
      sym_valid = 1'b1;
      SigI      = si;
      SigQ      = sq;
      tick();
      sym_valid = 1'b0;
   endtask

   initial begin
      int seq3[4];
      seq3[0] = 129;
      seq3[1] = 125;
      seq3[2] = -129;
      seq3[3] = -125;
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      sym_valid = 1'b0;
      SigI      = 2'b00;
      SigQ      = 2'b00;
      fcw       = '0;

      // 1: idle after reset, carrier running, outputs stay zero.
      fcw = 10'd256;
      do_reset();
      repeat (20) tick();

      // 2: frozen phase, single symbol +3/-3 gives 387 from the third edge on.
      fcw = 10'd0;
      do_reset();
      strobe(2'b10, 2'b00);
      chk("lat_valid_early", int'(out_valid), 0);
      tick();
      chk("lat_valid_early2", int'(out_valid), 0);
      tick();
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_value", int'(mod_out), 387);
      repeat (5) tick();
      chk("t2_hold", int'(mod_out), 387);

      // 3: symbol +1/-1 loaded at phase 0, then quarter-turn steps.
      fcw = 10'd0;
      do_reset();
      sym_valid = 1'b1;
      SigI      = 2'b11;
      SigQ      = 2'b01;
      tick();
      sym_valid = 1'b0;
      fcw       = 10'd256;
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t3_seq", int'(mod_out), seq3[i % 4]);
      end

      // 4: all 16 symbols back-to-back with frozen phase.
      fcw = 10'd0;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         logic [3:0] s;
         s = 4'(i);
         sym_valid = 1'b1;
         SigI      = s[3:2];
         SigQ      = s[1:0];
         tick();
         if (i == 4) chk("t4_sym_00_10", int'(mod_out), -387);
      end
      sym_valid = 1'b0;
      repeat (3) tick();

      // 5: negative frequency word, phase wraps 0 -> 1023 immediately.
      fcw = 10'd1023;
      do_reset();
      strobe(2'b01, 2'b10);
      for (int i = 0; i < 60; i++) begin
         if (i % 7 == 3) begin
            strobe(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         end else begin
            tick();
         end
      end

      // Random frequency words and sparse strobes.
      do_reset();
      for (int i = 0; i < 200; i++) begin
         if (i % 40 == 0) fcw = 10'($urandom_range(0, 1023));
         sym_valid = ($urandom_range(0, 3) == 0);
         SigI      = 2'($urandom_range(0, 3));
         SigQ      = 2'($urandom_range(0, 3));
         tick();
      end
      sym_valid = 1'b0;

      // 6: reset mid-stream after 50 active cycles, then recovery.
      fcw = 10'd37;
      do_reset();
      strobe(2'b10, 2'b00);
      repeat (50) tick();
      chk("t6_pre_valid", int'(out_valid), 1);
      do_reset();
      repeat (10) tick();
      strobe(2'b11, 2'b10);
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
